// File: rtl/v15_peak_detector.sv
// v15_peak_detector: finds pulses above a programmable threshold in the
// shaped-filter stream, records peak amplitude, peak timestamp and width,
// and queues each pulse as an event in a small first-word-fall-through FIFO.
// Optional feature macro: V15_PEAK_PILEUP_EN adds pile-up flagging
// (long pulses, or a second rise inside one pulse).
module v15_peak_detector #(
  parameter int DATA_W     = 16,
  parameter int TS_W       = 32,
  parameter int WIDTH_W    = 8,
  parameter int HOLDOFF    = 8,
  parameter int FIFO_DEPTH = 4
`ifdef V15_PEAK_PILEUP_EN
  ,
  parameter int MAX_WIDTH  = 64
`endif
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] filter_data,
  input  logic signed [DATA_W-1:0] threshold,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic signed [DATA_W-1:0] evt_peak,
  output logic [TS_W-1:0]          evt_ts,
  output logic [WIDTH_W-1:0]       evt_width,
  output logic                     evt_pileup,
  output logic [7:0]               ovf_count,
  output logic                     busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int HO_W  = $clog2(HOLDOFF + 1);

  typedef enum logic [1:0] {S_IDLE, S_TRACK, S_HOLD} state_t;

  state_t                   state, state_nxt;
  logic [HO_W-1:0]          hold_cnt, hold_nxt;

  logic signed [DATA_W-1:0] data_p0;
  logic                     vld_p0;
  logic [TS_W-1:0]          ts_p0;

  logic signed [DATA_W-1:0] thr_p1;
  logic signed [DATA_W-1:0] peak_p1;
  logic [TS_W-1:0]          peak_ts_p1;
  logic [WIDTH_W-1:0]       width_p1;
  logic [WIDTH_W-1:0]       width_inc;

  logic                     start, extend, push;
  logic                     pop, wr_en, drop, full, empty;
  logic [PTR_W:0]           wr_ptr, rd_ptr;
  logic [PTR_W-1:0]         wr_idx, rd_idx;

  logic signed [DATA_W-1:0] mem_peak  [FIFO_DEPTH];
  logic [TS_W-1:0]          mem_ts    [FIFO_DEPTH];
  logic [WIDTH_W-1:0]       mem_width [FIFO_DEPTH];

`ifdef V15_PEAK_PILEUP_EN
  localparam logic [WIDTH_W-1:0] MAX_WIDTH_L = WIDTH_W'(MAX_WIDTH);
  logic signed [DATA_W-1:0] prev_p1;
  logic                     fell_p1;
  logic                     pileup_p1;
  logic                     mem_pile [FIFO_DEPTH];
`endif

  function automatic logic [WIDTH_W-1:0] sat_inc_width(input logic [WIDTH_W-1:0] v);
    return (&v) ? v : v + WIDTH_W'(1);
  endfunction

  function automatic logic [7:0] sat_inc_cnt(input logic [7:0] v);
    return (&v) ? v : v + 8'd1;
  endfunction

  // ---- stage p0: input register and free-running timestamp ----
  // Sample register; vld_p0 marks it meaningful once reset has released.
  always_ff @(posedge clk) begin
    data_p0 <= filter_data;
  end

  // Valid flag and timestamp counter (wraps naturally).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p0 <= 1'b0;
      ts_p0  <= '0;
    end else begin
      vld_p0 <= 1'b1;
      ts_p0  <= ts_p0 + TS_W'(1);
    end
  end

  // ---- stage p1: pulse tracking FSM ----
  // State register and holdoff counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  // Next-state logic: arm in IDLE, follow the pulse in TRACK, dead time in HOLD.
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    start     = 1'b0;
    extend    = 1'b0;
    push      = 1'b0;
    case (state)
      S_IDLE: begin
        if (vld_p0 && (data_p0 > threshold)) begin
          start     = 1'b1;
          state_nxt = S_TRACK;
        end
      end
      S_TRACK: begin
        if (data_p0 > thr_p1) begin
          extend = 1'b1;
        end else begin
          push      = 1'b1;
          state_nxt = S_HOLD;
          hold_nxt  = HO_W'(HOLDOFF - 1);
        end
      end
      S_HOLD: begin
        if (hold_cnt == '0) state_nxt = S_IDLE;
        else                hold_nxt  = hold_cnt - HO_W'(1);
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign width_inc = sat_inc_width(width_p1);
  assign busy      = (state != S_IDLE);

  // Pulse measurement; threshold is frozen while a pulse is being followed.
  always_ff @(posedge clk) begin
    if (state == S_IDLE) thr_p1 <= threshold;
    if (start) begin
      peak_p1    <= data_p0;
      peak_ts_p1 <= ts_p0;
      width_p1   <= WIDTH_W'(1);
    end else if (extend) begin
      // strict compare keeps the earliest timestamp on a plateau
      if (data_p0 > peak_p1) begin
        peak_p1    <= data_p0;
        peak_ts_p1 <= ts_p0;
      end
      width_p1 <= width_inc;
    end
  end

`ifdef V15_PEAK_PILEUP_EN
  // Pile-up: pulse too long, or a rise seen after the pulse had started falling.
  always_ff @(posedge clk) begin
    if (start) begin
      prev_p1   <= data_p0;
      fell_p1   <= 1'b0;
      pileup_p1 <= (WIDTH_W'(1) >= MAX_WIDTH_L);
    end else if (extend) begin
      prev_p1   <= data_p0;
      fell_p1   <= fell_p1 | (data_p0 < prev_p1);
      pileup_p1 <= pileup_p1 | (fell_p1 && (data_p0 > prev_p1)) | (width_inc >= MAX_WIDTH_L);
    end
  end
`endif

  // ---- stage p2: event FIFO ----
  assign wr_idx    = wr_ptr[PTR_W-1:0];
  assign rd_idx    = rd_ptr[PTR_W-1:0];
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) && (wr_idx == rd_idx);
  assign evt_valid = !empty;
  assign pop       = evt_valid && evt_ready;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts
  assign wr_en     = push && (!full || pop);
  assign drop      = push && full && !pop;

  // Pointers and drop counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ovf_count <= '0;
    end else begin
      if (wr_en) wr_ptr    <= wr_ptr + (PTR_W+1)'(1);
      if (pop)   rd_ptr    <= rd_ptr + (PTR_W+1)'(1);
      if (drop)  ovf_count <= sat_inc_cnt(ovf_count);
    end
  end

  // Event storage.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_peak[wr_idx]  <= peak_p1;
      mem_ts[wr_idx]    <= peak_ts_p1;
      mem_width[wr_idx] <= width_p1;
`ifdef V15_PEAK_PILEUP_EN
      mem_pile[wr_idx]  <= pileup_p1;
`endif
    end
  end

  // Head entry shown only while valid, so an empty FIFO drives zeros.
  assign evt_peak  = evt_valid ? mem_peak[rd_idx]  : '0;
  assign evt_ts    = evt_valid ? mem_ts[rd_idx]    : '0;
  assign evt_width = evt_valid ? mem_width[rd_idx] : '0;
`ifdef V15_PEAK_PILEUP_EN
  assign evt_pileup = evt_valid ? mem_pile[rd_idx] : 1'b0;
`else
  assign evt_pileup = 1'b0;
`endif

endmodule
